vga_controller: RTL and testbench

VGA_CONTROLLER -- requirements
Module: vga_controller

---
 rtl/vga_controller.sv | 85 ++++++++
 tb/tb_vga_controller.sv | 110 +++++++++++
 2 files changed

// File: rtl/vga_controller.sv
// vga_controller: pixel-clock divider, h/v timing counters and registered RGB/sync outputs
module vga_controller #(
  parameter int CLK_DIV = 2,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] red_in,
  input  logic [3:0] green_in,
  input  logic [3:0] blue_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       visible,
  output logic       pix_en,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b
);
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DW      = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div_q, div_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic [3:0]    r_q, r_d, g_q, g_d, b_q, b_d;
  logic          pix_en_q, pix_en_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic          x_last, y_last, vis;
  always_comb begin
    x_last   = x_q == 10'(H_TOTAL - 1);
    y_last   = y_q == 10'(V_TOTAL - 1);
    vis      = x_q < 10'(H_VIS) && y_q < 10'(V_VIS);
    pix_en_d = div_q == DW'(CLK_DIV - 1);
    div_d    = pix_en_d ? '0 : div_q + 1'b1;
    x_d      = pix_en_q ? (x_last ? '0 : x_q + 1'b1) : x_q;
    y_d      = pix_en_q && x_last ? (y_last ? '0 : y_q + 1'b1) : y_q;
    // sync is registered alongside RGB so both carry the same one-pixel latency
    hsync_d  = pix_en_q ? !(x_q >= 10'(H_VIS + H_FP) && x_q < 10'(H_VIS + H_FP + H_SYNC)) : hsync_q;
    vsync_d  = pix_en_q ? !(y_q >= 10'(V_VIS + V_FP) && y_q < 10'(V_VIS + V_FP + V_SYNC)) : vsync_q;
    r_d      = pix_en_q ? (vis ? red_in : 4'h0) : r_q;
    g_d      = pix_en_q ? (vis ? green_in : 4'h0) : g_q;
    b_d      = pix_en_q ? (vis ? blue_in : 4'h0) : b_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      pix_en_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
    end else begin
      div_q    <= div_d;
      pix_en_q <= pix_en_d;
      x_q      <= x_d;
      y_q      <= y_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
    end
  end
  assign x           = x_q;
  assign y           = y_q;
  assign visible     = vis;
  assign pix_en      = pix_en_q;
  assign frame_start = pix_en_q && x_last && y_last;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
endmodule

// File: tb/tb_vga_controller.sv
// tb_vga_controller: random RGB against an arithmetic pixel-index model, CLK_DIV=1 and 2 side by side
module tb_vga_controller;
  localparam int HV = 10, HF = 2, HS = 3, HB = 3, VV = 5, VF = 1, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB, VT = VV + VF + VS + VB;
  logic       clk = 0, rst = 1;
  logic [3:0] red_in = 0, green_in = 0, blue_in = 0;
  logic [9:0] x [2], y [2];
  logic       visible [2], pix_en [2], frame_start [2], hsync [2], vsync [2];
  logic [3:0] vga_r [2], vga_g [2], vga_b [2];
  int         n_checks = 0, n_fail = 0;
  int         k = 0, cyc = 0, fs_cnt = 0;
  int         last_fs [2];
  logic [11:0] er [2];
  logic        eh [2], ev [2];
  always #5 clk = ~clk;
  vga_controller #(.CLK_DIV(1), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) u1 (
    .clk(clk), .rst(rst), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .x(x[0]), .y(y[0]), .visible(visible[0]), .pix_en(pix_en[0]), .frame_start(frame_start[0]),
    .hsync(hsync[0]), .vsync(vsync[0]), .vga_r(vga_r[0]), .vga_g(vga_g[0]), .vga_b(vga_b[0]));
  vga_controller #(.CLK_DIV(2), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) u2 (
    .clk(clk), .rst(rst), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .x(x[1]), .y(y[1]), .visible(visible[1]), .pix_en(pix_en[1]), .frame_start(frame_start[1]),
    .hsync(hsync[1]), .vsync(vsync[1]), .vga_r(vga_r[1]), .vga_g(vga_g[1]), .vga_b(vga_b[1]));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask
  // pixel index reached k edges after reset release, and whether pix_en is high then
  function automatic int npix(input int kk, input int d);
    return kk >= 1 ? (kk - 1) / d : 0;
  endfunction
  function automatic bit pe(input int kk, input int d);
    return kk >= d && kk % d == 0;
  endfunction
  task automatic init_model();
    k = 0;
    for (int i = 0; i < 2; i++) begin
      er[i] = '0; eh[i] = 1'b1; ev[i] = 1'b1; last_fs[i] = -1;
    end
  endtask
  task automatic reset_check(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_x_d%0d", tag, i + 1), 32'(x[i]), 0);
      check($sformatf("%s_y_d%0d", tag, i + 1), 32'(y[i]), 0);
      check($sformatf("%s_pix_en_d%0d", tag, i + 1), 32'(pix_en[i]), 0);
      check($sformatf("%s_fs_d%0d", tag, i + 1), 32'(frame_start[i]), 0);
      check($sformatf("%s_hsync_d%0d", tag, i + 1), 32'(hsync[i]), 1);
      check($sformatf("%s_vsync_d%0d", tag, i + 1), 32'(vsync[i]), 1);
      check($sformatf("%s_rgb_d%0d", tag, i + 1), 32'({vga_r[i], vga_g[i], vga_b[i]}), 0);
    end
  endtask
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < 2; i++) begin
        int m, px, py;
        m = npix(k, i + 1); px = m % HT; py = (m / HT) % VT;
        if (pe(k, i + 1)) begin
          er[i] = (px < HV && py < VV) ? {red_in, green_in, blue_in} : 12'h0;
          eh[i] = !(px >= HV + HF && px < HV + HF + HS);
          ev[i] = !(py >= VV + VF && py < VV + VF + VS);
        end
      end
      @(posedge clk);
      #1;
      k++; cyc++;
      for (int i = 0; i < 2; i++) begin
        int d, m, px, py;
        bit p;
        d = i + 1; m = npix(k, d); px = m % HT; py = (m / HT) % VT; p = pe(k, d);
        check($sformatf("x_d%0d", d), 32'(x[i]), 32'(px));
        check($sformatf("y_d%0d", d), 32'(y[i]), 32'(py));
        check($sformatf("visible_d%0d", d), 32'(visible[i]), 32'(px < HV && py < VV));
        check($sformatf("pix_en_d%0d", d), 32'(pix_en[i]), 32'(p));
        check($sformatf("fs_d%0d", d), 32'(frame_start[i]), 32'(p && px == HT - 1 && py == VT - 1));
        check($sformatf("rgb_d%0d", d), 32'({vga_r[i], vga_g[i], vga_b[i]}), 32'(er[i]));
        check($sformatf("hsync_d%0d", d), 32'(hsync[i]), 32'(eh[i]));
        check($sformatf("vsync_d%0d", d), 32'(vsync[i]), 32'(ev[i]));
        if (frame_start[i] === 1'b1) begin
          fs_cnt++;
          if (last_fs[i] >= 0) check($sformatf("frame_period_d%0d", d), 32'(cyc - last_fs[i]), 32'(d * HT * VT));
          last_fs[i] = cyc;
        end
      end
      red_in = 4'($urandom); green_in = 4'($urandom); blue_in = 4'($urandom);
    end
  endtask
  initial begin
    init_model();
    repeat (2) @(posedge clk);
    #1 reset_check("por");
    #2 rst = 0;
    run(3 * 2 * HT * VT + 7);
    run($urandom_range(0, 50));
    #2 rst = 1;
    #1 reset_check("async");
    @(posedge clk);
    #1 reset_check("held");
    #2 rst = 0;
    init_model();
    run(3 * 2 * HT * VT);
    check("fs_seen", 32'(fs_cnt >= 8), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
